gtx_lane_bringup: RTL
=====================

Name: gtx_lane_bringup

Overview:
- Parametrised bring-up and PRBS link-test controller for a quad (or N-lane) GTX block; replaces tying every transceiver control off to zero.
- Sequences PLL reset, GTX reset and PRBS enable for all lanes, waits for lock and reset-done with timeouts, then counts PRBS errors per lane.
- Sits between the software register interface and the GTX wrapper control/status pins.

Parameters:
- NUM_LANES, 4, number of GTX lanes controlled (1..16).
- ERR_CNT_W, 16, width of each per-lane saturating PRBS error counter.
- PLL_RST_CYCLES, 64, cycles pll_rx_reset is held high.
- GTX_RST_CYCLES, 32, cycles gtx_rx_reset/gtx_tx_reset are held high.
- TIMEOUT_CYCLES, 65536, maximum wait for lock or reset-done before FAIL.
- SETTLE_CYCLES, 256, cycles after reset-done before PRBS checking starts.

Ports:
- clk  in  1  control clock; all logic synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins the sequence from IDLE, RUN or FAIL.
- lane_en  in  NUM_LANES  lanes included in lock/done checks and error counting.
- prbs_mode  in  3  PRBS pattern select; captured on start.
- err_clear  in  1  one-cycle pulse; zeroes all error counters.
- pll_lock  in  NUM_LANES  per-lane RX PLL lock (asynchronous).
- rx_resetdone  in  NUM_LANES  per-lane RX reset done (asynchronous).
- tx_resetdone  in  NUM_LANES  per-lane TX reset done (asynchronous).
- prbs_err  in  NUM_LANES  per-lane PRBS error, one-cycle pulses synchronous to clk.
- pll_rx_reset  out  1  PLL reset to all lanes.
- gtx_rx_reset  out  1  GTX RX reset to all lanes.
- gtx_tx_reset  out  1  GTX TX reset to all lanes.
- enprbstst  out  3*NUM_LANES  per-lane PRBS enable (RX and TX share); lane i is bits [3i+2:3i].
- lane_up  out  NUM_LANES  lane enabled, locked and done while in RUN.
- err_count  out  NUM_LANES*ERR_CNT_W  per-lane error counts; lane i is bits [ERR_CNT_W*(i+1)-1:ERR_CNT_W*i].
- state  out  3  current FSM state encoding.
- fail  out  1  high while in FAIL.

Behaviour:
- Reset values: pll_rx_reset=1, gtx_rx_reset=1, gtx_tx_reset=1, enprbstst=0, lane_up=0, err_count=0, state=IDLE, fail=0.
- Synchronisation: pll_lock, rx_resetdone and tx_resetdone each pass through a 2-flop synchroniser, giving 2 cycles of latency. All checks below use the synchronised values.
- Lane masking: "all locked" means (lock | ~lane_en) is all ones; "all done" is defined the same way.
- Empty lane mask: if lane_en is all zero, start is ignored and the FSM stays in IDLE.
- FSM state encodings: IDLE=0, PLL_RST=1, WAIT_LOCK=2, GTX_RST=3, WAIT_DONE=4, SETTLE=5, RUN=6, FAIL=7.
- IDLE: all resets high. On start, capture prbs_mode and lane_en, then go to PLL_RST.
- PLL_RST: pll_rx_reset=1 for PLL_RST_CYCLES, then go to WAIT_LOCK.
- WAIT_LOCK: pll_rx_reset=0, GTX resets still high.
  - All locked: go to GTX_RST.
  - Timer reaches TIMEOUT_CYCLES: go to FAIL.
- GTX_RST: gtx_rx_reset and gtx_tx_reset held high for GTX_RST_CYCLES, then go to WAIT_DONE.
- WAIT_DONE: GTX resets low.
  - All RX and TX done: go to SETTLE.
  - Timeout: go to FAIL.
- SETTLE: enprbstst for enabled lanes driven with the captured mode; disabled lanes driven 0. After SETTLE_CYCLES, go to RUN.
- RUN:
  - lane_up[i] = en & lock & rx_done & tx_done for each lane.
  - An enabled lane that loses synchronised lock or rx_resetdone drops its lane_up in the same cycle and causes a transition to FAIL.
- FAIL: fail=1, enprbstst=0, pll_rx_reset, gtx_rx_reset and gtx_tx_reset held high. Leave only on start, which goes to PLL_RST.
- start in any non-IDLE/RUN/FAIL state: ignored.
- Timers: one shared counter, zeroed on every state entry.
- Error counters:
  - Count increments by 1 on prbs_err[i] only in RUN with lane i enabled.
  - Counters saturate at all ones and do not wrap.
  - err_clear takes priority over a simultaneous error pulse; the result is 0.
  - start also clears all counters.
- Registered outputs: all outputs are registered. A state change is visible on the outputs 1 cycle after the condition is sampled.

Optional Feature:
- Macro: GTX_BRINGUP_AUTORETRY_EN.
- When defined:
  - On entry to FAIL caused by a timeout or lock loss, the FSM waits 16 cycles and re-enters PLL_RST automatically.
  - A maximum of 3 retries is allowed; a 4-bit retry counter is cleared on start and on reaching RUN.
  - After 3 retries the FSM remains in FAIL.
  - An extra output retry_cnt [3:0] is added.
- When undefined: FAIL is sticky until start, and no retry_cnt port exists.

Test Plan:
- Nominal bring-up:
  - Stimulus: NUM_LANES=4, lane_en=4'hF, start with prbs_mode=3'b010; lock asserted 100 cycles after pll_rx_reset falls; resetdone asserted 50 cycles after the GTX resets fall.
  - Required: state reaches RUN=6, lane_up=4'hF, enprbstst=12'h492.
- Lock timeout:
  - Stimulus: lane 2 pll_lock held 0, lane_en=4'hF.
  - Required: exactly TIMEOUT_CYCLES after entering WAIT_LOCK, state=7, fail=1, all resets high.
- Lane masking:
  - Stimulus: lane_en=4'b1011 with lane 2 never locking.
  - Required: RUN is reached, lane_up=4'b1011, enprbstst bits [8:6]=0.
- Error counting:
  - Stimulus: in RUN, 5 prbs_err[1] pulses, then err_clear coincident with a 6th pulse.
  - Required: err_count lane 1 reads 5, then 0; other lanes stay 0.
- Saturation:
  - Stimulus: ERR_CNT_W=4, 20 consecutive prbs_err[0] pulses.
  - Required: lane 0 count holds at 4'hF.
- Lock loss and reset mid-operation:
  - Stimulus: drop pll_lock[0] in RUN.
  - Required: FAIL 3 cycles later, or with GTX_BRINGUP_AUTORETRY_EN, PLL_RST 16 cycles after FAIL entry with retry_cnt=1.
  - Then: rst_n pulsed low mid-sequence returns all outputs to their reset values immediately.

Source files
------------

// File: rtl/gtx_lane_bringup.sv
// Reset/PRBS bring-up sequencer for an N-lane GTX block with per-lane saturating error counters.
// Optional build macro GTX_BRINGUP_AUTORETRY_EN adds bounded automatic retry out of FAIL and a retry_cnt port.
module gtx_lane_bringup #(
  parameter int NUM_LANES      = 4,
  parameter int ERR_CNT_W      = 16,
  parameter int PLL_RST_CYCLES = 64,
  parameter int GTX_RST_CYCLES = 32,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int SETTLE_CYCLES  = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NUM_LANES-1:0]           lane_en,
  input  logic [2:0]                     prbs_mode,
  input  logic                           err_clear,
  input  logic [NUM_LANES-1:0]           pll_lock,
  input  logic [NUM_LANES-1:0]           rx_resetdone,
  input  logic [NUM_LANES-1:0]           tx_resetdone,
  input  logic [NUM_LANES-1:0]           prbs_err,
  output logic                           pll_rx_reset,
  output logic                           gtx_rx_reset,
  output logic                           gtx_tx_reset,
  output logic [3*NUM_LANES-1:0]         enprbstst,
  output logic [NUM_LANES-1:0]           lane_up,
  output logic [NUM_LANES*ERR_CNT_W-1:0] err_count,
  output logic [2:0]                     state,
`ifdef GTX_BRINGUP_AUTORETRY_EN
  output logic [3:0]                     retry_cnt,
`endif
  output logic                           fail
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PLL_RST   = 3'd1;
  localparam logic [2:0] S_WAIT_LOCK = 3'd2;
  localparam logic [2:0] S_GTX_RST   = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_SETTLE    = 3'd5;
  localparam logic [2:0] S_RUN       = 3'd6;
  localparam logic [2:0] S_FAIL      = 3'd7;

  // Timer is sized for the longest interval, including the 16-cycle retry wait.
  localparam int MAX_A = (PLL_RST_CYCLES > GTX_RST_CYCLES) ? PLL_RST_CYCLES : GTX_RST_CYCLES;
  localparam int MAX_B = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_D = (MAX_C > 16) ? MAX_C : 16;
  localparam int TMR_W = $clog2(MAX_D + 1);

  localparam logic [TMR_W-1:0] PLL_LAST    = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] GTX_LAST    = TMR_W'(GTX_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);

  logic [NUM_LANES-1:0] lock_meta, lock_sync;
  logic [NUM_LANES-1:0] rxd_meta, rxd_sync;
  logic [NUM_LANES-1:0] txd_meta, txd_sync;

  logic [2:0]           state_reg, state_next;
  logic [TMR_W-1:0]     timer_reg, timer_next;
  logic [2:0]           mode_reg;
  logic [NUM_LANES-1:0] en_reg;

  logic                 all_locked, all_done, lane_loss, start_go, capture;
  logic                 pll_next, gtx_next, fail_next, prbs_on;
  logic [NUM_LANES-1:0] up_next;
  logic [3*NUM_LANES-1:0] prbs_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= '0;
      lock_sync <= '0;
      rxd_meta  <= '0;
      rxd_sync  <= '0;
      txd_meta  <= '0;
      txd_sync  <= '0;
    end else begin
      lock_meta <= pll_lock;
      lock_sync <= lock_meta;
      rxd_meta  <= rx_resetdone;
      rxd_sync  <= rxd_meta;
      txd_meta  <= tx_resetdone;
      txd_sync  <= txd_meta;
    end
  end

  assign all_locked = &(lock_sync | ~en_reg);
  assign all_done   = &((rxd_sync & txd_sync) | ~en_reg);
  assign lane_loss  = |(en_reg & ~(lock_sync & rxd_sync));
  assign start_go   = start && (lane_en != '0);
  assign capture    = start_go &&
                      ((state_reg == S_IDLE) || (state_reg == S_RUN) || (state_reg == S_FAIL));

`ifdef GTX_BRINGUP_AUTORETRY_EN
  logic [3:0] retry_reg;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (start_go) state_next = S_PLL_RST;
      S_PLL_RST:   if (timer_reg == PLL_LAST) state_next = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (all_locked) state_next = S_GTX_RST;
        else if (timer_reg == TMO_LAST) state_next = S_FAIL;
      end
      S_GTX_RST:   if (timer_reg == GTX_LAST) state_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (all_done) state_next = S_SETTLE;
        else if (timer_reg == TMO_LAST) state_next = S_FAIL;
      end
      S_SETTLE:    if (timer_reg == SETTLE_LAST) state_next = S_RUN;
      S_RUN: begin
        if (start_go) state_next = S_PLL_RST;
        else if (lane_loss) state_next = S_FAIL;
      end
      S_FAIL: begin
        if (start_go) state_next = S_PLL_RST;
`ifdef GTX_BRINGUP_AUTORETRY_EN
        else if ((retry_reg < 4'd3) && (timer_reg == TMR_W'(15))) state_next = S_PLL_RST;
`endif
      end
      default:     state_next = S_IDLE;
    endcase
  end

  // Shared timer restarts from zero on every state entry and saturates otherwise.
  always_comb begin
    if (state_next != state_reg) timer_next = '0;
    else if (timer_reg == '1) timer_next = timer_reg;
    else timer_next = timer_reg + TMR_W'(1);
  end

  // Outputs are decoded from the next state so they update together with state.
  always_comb begin
    pll_next  = 1'b1;
    gtx_next  = 1'b1;
    fail_next = 1'b0;
    prbs_on   = 1'b0;
    up_next   = '0;
    case (state_next)
      S_WAIT_LOCK, S_GTX_RST: pll_next = 1'b0;
      S_WAIT_DONE: begin
        pll_next = 1'b0;
        gtx_next = 1'b0;
      end
      S_SETTLE: begin
        pll_next = 1'b0;
        gtx_next = 1'b0;
        prbs_on  = 1'b1;
      end
      S_RUN: begin
        pll_next = 1'b0;
        gtx_next = 1'b0;
        prbs_on  = 1'b1;
        up_next  = en_reg & lock_sync & rxd_sync & txd_sync;
      end
      S_FAIL:  fail_next = 1'b1;
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [ERR_CNT_W-1:0] cnt_reg;

      assign prbs_next[3*gi +: 3] = (prbs_on && en_reg[gi]) ? mode_reg : 3'b000;

      // Clear wins over a coincident error pulse; count sticks at all ones.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (err_clear || capture) begin
          cnt_reg <= '0;
        end else if ((state_reg == S_RUN) && en_reg[gi] && prbs_err[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + ERR_CNT_W'(1);
        end
      end

      assign err_count[ERR_CNT_W*gi +: ERR_CNT_W] = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      timer_reg    <= '0;
      mode_reg     <= 3'b000;
      en_reg       <= '0;
      pll_rx_reset <= 1'b1;
      gtx_rx_reset <= 1'b1;
      gtx_tx_reset <= 1'b1;
      enprbstst    <= '0;
      lane_up      <= '0;
      fail         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      if (capture) begin
        mode_reg <= prbs_mode;
        en_reg   <= lane_en;
      end
      pll_rx_reset <= pll_next;
      gtx_rx_reset <= gtx_next;
      gtx_tx_reset <= gtx_next;
      enprbstst    <= prbs_next;
      lane_up      <= up_next;
      fail         <= fail_next;
    end
  end

  assign state = state_reg;

`ifdef GTX_BRINGUP_AUTORETRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_reg <= 4'd0;
    end else if (capture || ((state_reg == S_SETTLE) && (state_next == S_RUN))) begin
      retry_reg <= 4'd0;
    end else if ((state_reg == S_FAIL) && (state_next == S_PLL_RST)) begin
      retry_reg <= retry_reg + 4'd1;
    end
  end

  assign retry_cnt = retry_reg;
`endif

endmodule
